// File: rtl/rope_pkg.sv
// Shared types and constants for the rope/claw motion engine.
// The optional dynamite feature is enabled with ROPE_DYNAMITE_EN.
package rope_pkg;

    typedef enum logic [1:0] {
        SWING   = 2'd0,
        EXTEND  = 2'd1,
        RETRACT = 2'd2,
        DELIVER = 2'd3
    } state_t;

    // Q1.8 unit value for sin/cos
    localparam int Q_ONE = 256;
    // Quarter-wave table entries, 0..90 degrees
    localparam int LUT_DEPTH = 91;

endpackage

// File: rtl/rope_trig_lut.sv
// Combinational Q1.8 sin/cos of 0..180 degrees from a quarter-wave table.
// Angles past 90 fold back with cos(180-d) = -cos(d).
module rope_trig_lut
    import rope_pkg::*;
(
    input  logic [7:0]        deg,
    output logic signed [9:0] sin_q,
    output logic signed [9:0] cos_q
);

    localparam logic [8:0] SIN_TAB [LUT_DEPTH] = '{
        9'd0,   9'd4,   9'd9,   9'd13,  9'd18,
        9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
        9'd44,  9'd49,  9'd53,  9'd58,  9'd62,
        9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
        9'd88,  9'd92,  9'd96,  9'd100, 9'd104,
        9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
        9'd128, 9'd132, 9'd136, 9'd139, 9'd143,
        9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
        9'd165, 9'd168, 9'd171, 9'd175, 9'd178,
        9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
        9'd196, 9'd199, 9'd202, 9'd204, 9'd207,
        9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
        9'd222, 9'd224, 9'd226, 9'd228, 9'd230,
        9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
        9'd241, 9'd242, 9'd243, 9'd245, 9'd246,
        9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
        9'd252, 9'd253, 9'd254, 9'd254, 9'd255,
        9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
        9'd256
    };

    logic [7:0] fold;
    logic [6:0] s_idx;
    logic [6:0] c_idx;
    logic       neg;

    always_comb begin
        fold = 8'd0;
        neg  = 1'b0;
        if (deg <= 8'd90) begin
            fold = deg;
        end else if (deg < 8'd180) begin
            fold = 8'd180 - deg;
            neg  = 1'b1;
        end else begin
            neg  = 1'b1;
        end
        s_idx = fold[6:0];
        c_idx = 7'd90 - fold[6:0];
        sin_q = $signed({1'b0, SIN_TAB[s_idx]});
        cos_q = neg ? -$signed({1'b0, SIN_TAB[c_idx]})
                    :  $signed({1'b0, SIN_TAB[c_idx]});
    end

endmodule

// File: rtl/rope_claw_fsm.sv
// Claw/rope motion engine: swing, extend, weighted retract, deliver.
// Define ROPE_DYNAMITE_EN to add the drop input for discarding a load.
module rope_claw_fsm
    import rope_pkg::*;
#(
    parameter int ORIGIN_X      = 160,
    parameter int ORIGIN_Y      = 45,
    parameter int SCREEN_W      = 320,
    parameter int SCREEN_H      = 240,
    parameter int LEN_W         = 8,
    parameter int MIN_LEN       = 10,
    parameter int MAX_LEN       = 200,
    parameter int DEG_MIN       = 10,
    parameter int DEG_MAX       = 170,
    parameter int SWING_STEP    = 2,
    parameter int EXTEND_SPEED  = 3,
    parameter int RETRACT_SPEED = 4,
    parameter int ID_W          = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick,
    input  logic             fire,
    input  logic             hit,
    input  logic [ID_W-1:0]  hit_id,
    input  logic [1:0]       hit_weight,
`ifdef ROPE_DYNAMITE_EN
    input  logic             drop,
`endif
    output logic [8:0]       end_x,
    output logic [7:0]       end_y,
    output logic [LEN_W-1:0] rope_len,
    output logic [7:0]       degree,
    output logic [1:0]       state,
    output logic             catch_valid,
    output logic [ID_W-1:0]  catch_id,
    output logic [1:0]       catch_weight
);

    localparam int SW = LEN_W + 12;

    localparam logic [7:0] D_MAX = 8'(DEG_MAX);
    localparam logic [7:0] D_MIN = 8'(DEG_MIN);
    localparam logic [7:0] D_STEP = 8'(SWING_STEP);

    localparam logic [LEN_W-1:0] L_MIN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] L_EXT = LEN_W'(EXTEND_SPEED);
    localparam logic [LEN_W-1:0] L_RET = LEN_W'(RETRACT_SPEED);

    localparam logic signed [SW-1:0] OX    = SW'(ORIGIN_X);
    localparam logic signed [SW-1:0] OY    = SW'(ORIGIN_Y);
    localparam logic signed [SW-1:0] X_LIM = SW'(SCREEN_W - 1);
    localparam logic signed [SW-1:0] Y_LIM = SW'(SCREEN_H);
    localparam logic signed [SW-1:0] X_SAT = SW'(511);
    localparam logic signed [SW-1:0] Y_SAT = SW'(255);

    state_t          st;
    logic            dir_up;
    logic            loaded;
    logic            fire_pending;
    logic            off_screen;
    logic [ID_W-1:0] item_id;
    logic [1:0]      item_weight;

    logic signed [9:0] sin_q;
    logic signed [9:0] cos_q;

    rope_trig_lut u_lut (
        .deg   (degree),
        .sin_q (sin_q),
        .cos_q (cos_q)
    );

    assign state = st;

    logic signed [LEN_W+9:0] prod_x;
    logic signed [LEN_W+9:0] prod_y;
    logic signed [LEN_W+9:0] dx;
    logic        [LEN_W+9:0] dy;
    logic signed [SW-1:0]    sx;
    logic signed [SW-1:0]    sy;
    logic [8:0]              ex_n;
    logic [7:0]              ey_n;
    logic                    off_n;

    always_comb begin
        prod_x = $signed({10'd0, rope_len})
               * $signed({{LEN_W{cos_q[9]}}, cos_q});
        prod_y = $signed({10'd0, rope_len})
               * $signed({{LEN_W{sin_q[9]}}, sin_q});
        dx = prod_x >>> 8;
        dy = prod_y >> 8;
        sx = OX + $signed({{2{dx[LEN_W+9]}}, dx});
        sy = OY + $signed({2'b00, dy});
        ex_n = 9'd0;
        if (sx > X_SAT) ex_n = 9'd511;
        else if (sx >= 0) ex_n = sx[8:0];
        ey_n = 8'd0;
        if (sy > Y_SAT) ey_n = 8'd255;
        else if (sy >= 0) ey_n = sy[7:0];
        off_n = (sx < 0) || (sx > X_LIM) || (sy >= Y_LIM);
    end

    logic drop_now;
`ifdef ROPE_DYNAMITE_EN
    assign drop_now = drop & loaded;
`else
    assign drop_now = 1'b0;
`endif

    logic             eff_loaded;
    logic [LEN_W-1:0] sp_loaded;
    logic [LEN_W-1:0] speed;
    logic [LEN_W:0]   ext_sum;
    logic             ext_max;
    logic             ret_done;
    logic             swing_hi;
    logic             swing_lo;

    always_comb begin
        eff_loaded = loaded & ~drop_now;
        // Heavier items slow the winch, but never to a standstill
        sp_loaded = L_RET >> item_weight;
        if (sp_loaded == '0) sp_loaded = LEN_W'(1);
        speed    = eff_loaded ? sp_loaded : L_RET;
        ext_sum  = {1'b0, rope_len} + {1'b0, L_EXT};
        ext_max  = ext_sum >= {1'b0, L_MAX};
        ret_done = {1'b0, rope_len} <= ({1'b0, L_MIN} + {1'b0, speed});
        swing_hi = degree >= (D_MAX - D_STEP);
        swing_lo = degree <= (D_MIN + D_STEP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st           <= SWING;
            degree       <= 8'd90;
            dir_up       <= 1'b1;
            rope_len     <= L_MIN;
            loaded       <= 1'b0;
            fire_pending <= 1'b0;
            item_id      <= '0;
            item_weight  <= 2'd0;
            catch_valid  <= 1'b0;
            catch_id     <= '0;
            catch_weight <= 2'd0;
            end_x        <= 9'(ORIGIN_X);
            end_y        <= 8'(ORIGIN_Y + MIN_LEN);
            off_screen   <= 1'b0;
        end else if (!enable) begin
            fire_pending <= 1'b0;
        end else begin
            end_x       <= ex_n;
            end_y       <= ey_n;
            off_screen  <= off_n;
            catch_valid <= 1'b0;
            unique case (st)
                SWING: begin
                    if (tick && fire_pending) begin
                        st           <= EXTEND;
                        fire_pending <= 1'b0;
                    end else begin
                        if (fire) fire_pending <= 1'b1;
                        if (tick && dir_up) begin
                            if (swing_hi) begin
                                degree <= D_MAX;
                                dir_up <= 1'b0;
                            end else begin
                                degree <= degree + D_STEP;
                            end
                        end else if (tick) begin
                            if (swing_lo) begin
                                degree <= D_MIN;
                                dir_up <= 1'b1;
                            end else begin
                                degree <= degree - D_STEP;
                            end
                        end
                    end
                end
                EXTEND: begin
                    if (tick) begin
                        if (hit) begin
                            item_id     <= hit_id;
                            item_weight <= hit_weight;
                            loaded      <= 1'b1;
                            st          <= RETRACT;
                        end else if (ext_max) begin
                            rope_len <= L_MAX;
                            st       <= RETRACT;
                        end else if (off_screen) begin
                            st <= RETRACT;
                        end else begin
                            rope_len <= ext_sum[LEN_W-1:0];
                        end
                    end
                end
                RETRACT: begin
                    if (tick) begin
                        if (drop_now) loaded <= 1'b0;
                        if (ret_done) begin
                            rope_len <= L_MIN;
                            st       <= eff_loaded ? DELIVER : SWING;
                        end else begin
                            rope_len <= rope_len - speed;
                        end
                    end
                end
                DELIVER: begin
                    catch_valid  <= 1'b1;
                    catch_id     <= item_id;
                    catch_weight <= item_weight;
                    loaded       <= 1'b0;
                    st           <= SWING;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rope_claw_fsm.sv
// Randomized bench for rope_claw_fsm against a trig-based reference model.
// Build with ROPE_DYNAMITE_EN to also exercise the drop input.
module tb_rope_claw_fsm;

`ifdef ROPE_DYNAMITE_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic       fire = 1'b0;
    logic       hit = 1'b0;
    logic [4:0] hit_id = '0;
    logic [1:0] hit_weight = '0;
    logic       drop = 1'b0;
    logic [8:0] end_x;
    logic [7:0] end_y;
    logic [7:0] rope_len;
    logic [7:0] degree;
    logic [1:0] state;
    logic       catch_valid;
    logic [4:0] catch_id;
    logic [1:0] catch_weight;

    always #5 clk = ~clk;

    rope_claw_fsm dut (
        .clock        (clk),
        .reset        (reset),
        .enable       (enable),
        .tick         (tick),
        .fire         (fire),
        .hit          (hit),
        .hit_id       (hit_id),
        .hit_weight   (hit_weight),
`ifdef ROPE_DYNAMITE_EN
        .drop         (drop),
`endif
        .end_x        (end_x),
        .end_y        (end_y),
        .rope_len     (rope_len),
        .degree       (degree),
        .state        (state),
        .catch_valid  (catch_valid),
        .catch_id     (catch_id),
        .catch_weight (catch_weight)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state (0 swing, 1 extend, 2 retract, 3 deliver)
    int m_st, m_deg, m_dir, m_len, m_loaded, m_fp;
    int m_id, m_w, m_cv, m_cid, m_cw, m_ex, m_ey, m_off;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q8(input real v);
        real s;
        s = 256.0 * v;
        return (s < 0.0) ? -$rtoi(-s + 0.5) : $rtoi(s + 0.5);
    endfunction

    function automatic void endpoint(input int len, input int deg,
                                     output int ex, output int ey,
                                     output int off);
        real r;
        int c, s, x, y;
        r = deg * 3.14159265358979 / 180.0;
        c = q8($cos(r));
        s = q8($sin(r));
        x = 160 + ((len * c) >>> 8);
        y = 45 + ((len * s) >>> 8);
        off = (x < 0 || x > 319 || y >= 240) ? 1 : 0;
        ex = (x < 0) ? 0 : (x > 511) ? 511 : x;
        ey = (y < 0) ? 0 : (y > 255) ? 255 : y;
    endfunction

    task automatic model(input bit rs, en, tk, fi, hi,
                         input int hid, hw, input bit dr);
        int nx, ny, noff, sp, ld;
        if (rs) begin
            m_st = 0; m_deg = 90; m_dir = 1; m_len = 10;
            m_loaded = 0; m_fp = 0; m_id = 0; m_w = 0;
            m_cv = 0; m_cid = 0; m_cw = 0;
            m_ex = 160; m_ey = 55; m_off = 0;
            return;
        end
        if (!en) begin
            m_fp = 0;
            return;
        end
        endpoint(m_len, m_deg, nx, ny, noff);
        m_cv = 0;
        case (m_st)
            0: begin
                if (tk && m_fp != 0) begin
                    m_st = 1;
                    m_fp = 0;
                end else begin
                    if (fi) m_fp = 1;
                    if (tk) begin
                        m_deg += 2 * m_dir;
                        if (m_deg >= 170) begin m_deg = 170; m_dir = -1; end
                        if (m_deg <= 10) begin m_deg = 10; m_dir = 1; end
                    end
                end
            end
            1: if (tk) begin
                if (hi) begin
                    m_id = hid; m_w = hw; m_loaded = 1; m_st = 2;
                end else if (m_len + 3 >= 200) begin
                    m_len = 200; m_st = 2;
                end else if (m_off != 0) begin
                    m_st = 2;
                end else begin
                    m_len += 3;
                end
            end
            2: if (tk) begin
                ld = m_loaded;
                if (DYN && dr && m_loaded != 0) begin
                    ld = 0; m_loaded = 0;
                end
                sp = 4;
                if (ld != 0) sp = ((4 >> m_w) < 1) ? 1 : (4 >> m_w);
                if (m_len <= 10 + sp) begin
                    m_len = 10;
                    m_st = (ld != 0) ? 3 : 0;
                end else begin
                    m_len -= sp;
                end
            end
            default: begin
                m_cv = 1; m_cid = m_id; m_cw = m_w;
                m_loaded = 0; m_st = 0;
            end
        endcase
        m_ex = nx; m_ey = ny; m_off = noff;
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_st));
        chk("degree", 32'(degree), 32'(m_deg));
        chk("rope_len", 32'(rope_len), 32'(m_len));
        chk("end_x", 32'(end_x), 32'(m_ex));
        chk("end_y", 32'(end_y), 32'(m_ey));
        chk("catch_valid", 32'(catch_valid), 32'(m_cv));
        chk("catch_id", 32'(catch_id), 32'(m_cid));
        chk("catch_weight", 32'(catch_weight), 32'(m_cw));
    endtask

    task automatic step(input bit rs, en, tk, fi, hi,
                        input int hid, hw, input bit dr);
        @(negedge clk);
        reset = rs; enable = en; tick = tk; fire = fi; hit = hi;
        hit_id = 5'(hid); hit_weight = 2'(hw); drop = dr;
        model(rs, en, tk, fi, hi, hid, hw, dr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tk1();
        step(0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    // Drop the claw straight down and extend ten ticks to length 40
    task automatic drop_to_40();
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        tk1();
        chk("ext_entry", 32'(state), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, (i == 4), 0, 0, 0, 0);
            idle();
        end
    endtask

    initial begin
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_degree", 32'(degree), 32'd90);
        chk("rst_len", 32'(rope_len), 32'd10);
        chk("rst_end_x", 32'(end_x), 32'd160);
        chk("rst_end_y", 32'(end_y), 32'd55);
        chk("rst_catch", 32'(catch_valid), 32'd0);
        tk1();
        chk("tick1_degree", 32'(degree), 32'd92);

        step(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) tk1();
        chk("swing_clamp", 32'(degree), 32'd170);
        tk1();
        chk("swing_flip", 32'(degree), 32'd168);

        drop_to_40();
        chk("ext_len40", 32'(rope_len), 32'd40);
        chk("ext_end_x", 32'(end_x), 32'd160);
        chk("ext_end_y", 32'(end_y), 32'd85);
        step(0, 1, 1, 0, 1, 7, 2, 0);
        chk("hit_state", 32'(state), 32'd2);
        for (int i = 0; i < 29; i++) tk1();
        chk("ret_len11", 32'(rope_len), 32'd11);
        tk1();
        chk("ret_deliver", 32'(state), 32'd3);
        chk("ret_min", 32'(rope_len), 32'd10);
        idle();
        chk("catch_pulse", 32'(catch_valid), 32'd1);
        chk("catch_id7", 32'(catch_id), 32'd7);
        chk("catch_w2", 32'(catch_weight), 32'd2);
        idle();
        chk("catch_once", 32'(catch_valid), 32'd0);
        tk1();
        chk("no_spurious", 32'(state), 32'd0);

        if (DYN) begin
            drop_to_40();
            step(0, 1, 1, 0, 1, 9, 3, 0);
            step(0, 1, 1, 0, 0, 0, 0, 1);
            chk("dyn_speed", 32'(rope_len), 32'd36);
            for (int i = 0; i < 7; i++) tk1();
            chk("dyn_state", 32'(state), 32'd0);
            chk("dyn_len", 32'(rope_len), 32'd10);
            idle();
            chk("dyn_nocatch", 32'(catch_valid), 32'd0);
        end

        step(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 500) == 0,
                 ($urandom % 25) != 0,
                 ($urandom % 2) == 1,
                 ($urandom % 12) == 0,
                 ($urandom % 6) == 0,
                 int'($urandom % 32),
                 int'($urandom % 4),
                 ($urandom % 10) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
